// File: rtl/phy_pkg.sv
// phy_pkg -- definitions shared by the two-lane serial PHY (phy_tx / phy_rx).
//   COMMA_BC      : idle / alignment symbol.
//   link_state_t  : link FSM encoding (SEARCH / LOCK / ACTIVE).
//   slot_t        : which byte slot of a word is on the lanes.
//   SLOT_*_LSB    : byte-striping map, i.e. where each lane byte lands in the word.
//   stripe_word() : assembles a 32-bit word from its four lane bytes.
package phy_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } link_state_t;

  typedef enum logic {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } slot_t;

  // Slot A carries the upper half-word and slot B the lower half-word.
  // Within each slot, lane 0 carries the more significant byte.
  localparam int SLOT_A_LANE0_LSB = 24;
  localparam int SLOT_A_LANE1_LSB = 16;
  localparam int SLOT_B_LANE0_LSB = 8;
  localparam int SLOT_B_LANE1_LSB = 0;

  function automatic logic [31:0] stripe_word(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] b0, input logic [7:0] b1);
    logic [31:0] word;
    word = '0;
    word[SLOT_A_LANE0_LSB +: 8] = a0;
    word[SLOT_A_LANE1_LSB +: 8] = a1;
    word[SLOT_B_LANE0_LSB +: 8] = b0;
    word[SLOT_B_LANE1_LSB +: 8] = b1;
    return word;
  endfunction

endpackage

// File: rtl/phy_rx_lane.sv
// phy_rx_lane -- one receive lane: 8-bit deserializing shift register plus
// comma detector. Bits arrive MSB first; each new bit enters at the LSB.
//   clk_32f  in  : bit clock, one bit per cycle.
//   reset_L  in  : synchronous active-low reset; clears the shift register.
//   serial   in  : serial lane input.
//   rx_byte  out : the last eight bits received (oldest bit in [7]).
//   is_comma out : rx_byte equals COMMA.
module phy_rx_lane
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_BC
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       serial,
  output logic [7:0] rx_byte,
  output logic       is_comma
);

  logic [7:0] shift;

  // NOTE: reset is sampled only on the clock edge (no sensitivity to reset_L),
  // and all state uses non-blocking assignments so every register sees the
  // values from before the edge.
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      shift <= '0;
    end else begin
      shift <= {shift[6:0], serial};
    end
  end

  assign rx_byte  = shift;
  assign is_comma = (shift == COMMA);

endmodule

// File: rtl/phy_rx.sv
// phy_rx -- receive end of the two-lane serial PHY link. Deserializes both
// lanes, aligns to the comma, then rebuilds 32-bit words from byte slots.
//   clk_32f        in     : sole clock, one serial bit per lane per cycle.
//   reset_L        in     : synchronous active-low reset.
//   phy_rx_in_0    in     : serial lane 0, MSB first.
//   phy_rx_in_1    in     : serial lane 1, MSB first, bit-aligned with lane 0.
//   data_out       out 32 : reassembled word, held between strobes.
//   valid_out      out    : one-cycle strobe marking a new data_out.
//   active_out     out    : link locked (FSM in ACTIVE).
//   word_count_out out 16 : saturating count of valid_out pulses; present only
//                           when the macro PHY_RX_WORD_CNT_EN is defined.
module phy_rx
  import phy_pkg::*;
#(
  parameter logic [7:0]  COMMA       = COMMA_BC,
  parameter int unsigned LOCK_COMMAS = 4  // legal range 1..15
) (
  input  logic        clk_32f,
  input  logic        reset_L,
  input  logic        phy_rx_in_0,
  input  logic        phy_rx_in_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active_out
`ifdef PHY_RX_WORD_CNT_EN
  ,
  output logic [15:0] word_count_out
`endif
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COMMAS);

  logic [7:0]  byte_0, byte_1;
  logic        comma_0, comma_1;
  logic        both_comma, boundary, word_done;

  link_state_t state;
  slot_t       phase;
  logic [2:0]  bit_cnt;
  logic [3:0]  comma_cnt;
  logic [7:0]  slot_a_0, slot_a_1;

  phy_rx_lane #(.COMMA(COMMA)) u_lane_0 (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .serial  (phy_rx_in_0),
    .rx_byte (byte_0),
    .is_comma(comma_0)
  );

  phy_rx_lane #(.COMMA(COMMA)) u_lane_1 (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .serial  (phy_rx_in_1),
    .rx_byte (byte_1),
    .is_comma(comma_1)
  );

  // A full byte sits in both shift registers when the counter reads 7; the
  // counter wraps to 0 on that same edge, so loading 0 on a SEARCH match makes
  // the matching cycle behave exactly like a byte boundary.
  assign both_comma = comma_0 & comma_1;
  assign boundary   = (bit_cnt == 3'd7);
  assign word_done  = (state == ACTIVE) && boundary && (phase == SLOT_B);

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state      <= SEARCH;
      phase      <= SLOT_A;
      bit_cnt    <= '0;
      comma_cnt  <= '0;
      slot_a_0   <= '0;
      slot_a_1   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      // NOTE: the strobe defaults low every cycle and is raised only in the
      // cycle a word completes, which makes it a single-cycle pulse.
      valid_out <= 1'b0;

      case (state)
        SEARCH: begin
          if (both_comma) begin
            bit_cnt   <= '0;
            comma_cnt <= 4'd1;
            if (LOCK_TARGET == 4'd1) begin
              state      <= ACTIVE;
              active_out <= 1'b1;
            end else begin
              state <= LOCK;
            end
          end
        end

        LOCK: begin
          if (boundary) begin
            if (both_comma) begin
              comma_cnt <= comma_cnt + 4'd1;
              if (comma_cnt + 4'd1 == LOCK_TARGET) begin
                state      <= ACTIVE;
                active_out <= 1'b1;
              end
            end else begin
              // One-lane comma or data: alignment is not trusted.
              state     <= SEARCH;
              comma_cnt <= '0;
            end
          end
        end

        ACTIVE: begin
          if (boundary) begin
            if (phase == SLOT_A) begin
              // A comma pair in slot A is idle; a word never starts with one.
              if (!both_comma) begin
                slot_a_0 <= byte_0;
                slot_a_1 <= byte_1;
                phase    <= SLOT_B;
              end
            end else begin
              data_out  <= stripe_word(slot_a_0, slot_a_1, byte_0, byte_1);
              valid_out <= 1'b1;
              phase     <= SLOT_A;
            end
          end
        end

        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

`ifdef PHY_RX_WORD_CNT_EN
  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      word_count_out <= '0;
    end else if (word_done && (word_count_out != 16'hFFFF)) begin
      word_count_out <= word_count_out + 16'd1;
    end
  end
`else
  logic unused_word_done;
  assign unused_word_done = word_done;
`endif

endmodule

// File: tb/tb_phy_rx.sv
// tb_phy_rx -- directed self-checking bench for phy_rx.
// Drives both lanes bit by bit on the falling edge; a monitor samples 1 ns
// after each rising edge and logs valid_out pulses and the active_out rise
// with the time of the rising edge that produced them. Expected pulse time is
// the rising edge that sampled the last slot-B bit plus one clock period.
`timescale 1ns/1ps
module tb_phy_rx;

  localparam int PERIOD = 10;
  localparam logic [7:0] C = 8'hBC;

  logic        clk_32f = 1'b0;
  logic        reset_L = 1'b0;
  logic        phy_rx_in_0 = 1'b0;
  logic        phy_rx_in_1 = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active_out;
`ifdef PHY_RX_WORD_CNT_EN
  logic [15:0] word_count_out;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] pulse_t[$];
  logic [31:0] pulse_d[$];
  logic [31:0] t_rise = '0;
  logic        act_prev = 1'b0;
  logic [31:0] t_last = '0;

  phy_rx #(.COMMA(8'hBC), .LOCK_COMMAS(4)) dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .phy_rx_in_0(phy_rx_in_0),
    .phy_rx_in_1(phy_rx_in_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active_out (active_out)
`ifdef PHY_RX_WORD_CNT_EN
    ,
    .word_count_out(word_count_out)
`endif
  );

  always #(PERIOD / 2) clk_32f = ~clk_32f;

  always @(posedge clk_32f) begin
    #1;
    if (active_out && !act_prev) t_rise = 32'($time) - 32'd1;
    act_prev = active_out;
    if (valid_out) begin
      pulse_t.push_back(32'($time) - 32'd1);
      pulse_d.push_back(data_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic clear_log();
    pulse_t.delete();
    pulse_d.delete();
    t_rise = '0;
  endtask

  // Called while sitting on a falling edge; returns on the next falling edge.
  task automatic send_bit(input logic b0, input logic b1);
    phy_rx_in_0 = b0;
    phy_rx_in_1 = b1;
    @(posedge clk_32f);
    t_last = 32'($time);
    @(negedge clk_32f);
  endtask

  task automatic send_slot(input logic [7:0] l0, input logic [7:0] l1);
    for (int i = 7; i >= 0; i--) send_bit(l0[i], l1[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    send_slot(w[31:24], w[23:16]);
    send_slot(w[15:8], w[7:0]);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_slot(C, C);
  endtask

  task automatic do_reset();
    reset_L     = 1'b0;
    phy_rx_in_0 = 1'b0;
    phy_rx_in_1 = 1'b0;
    @(posedge clk_32f);
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
    clear_log();
  endtask

  logic [31:0] t4;
  logic [31:0] tw[3];
  logic [31:0] words3[3];
  logic [2:0]  prefix;

  initial begin
    words3[0] = 32'hEEEEEEEE;
    words3[1] = 32'hDDDDDDDD;
    words3[2] = 32'hCCCCCCCC;
    prefix    = 3'b010;

    @(negedge clk_32f);
    do_reset();
    check("rst_data", data_out, 32'h0);
    check("rst_valid", {31'b0, valid_out}, 32'h0);
    check("rst_active", {31'b0, active_out}, 32'h0);

    // 1: four comma slots lock the link
    send_commas(4);
    t4 = t_last;
    check("t1_active_early", {31'b0, active_out}, 32'h0);
    send_commas(1);
    check("t1_active", {31'b0, active_out}, 32'h1);
    check("t1_rise_time", t_rise, t4 + PERIOD);
    check("t1_no_pulse", 32'(pulse_t.size()), 32'd0);

    // 2: single all-ones word
    send_word(32'hFFFFFFFF);
    tw[0] = t_last;
    send_commas(1);
    check("t2_pulses", 32'(pulse_t.size()), 32'd1);
    if (pulse_t.size() == 1) begin
      check("t2_data", pulse_d[0], 32'hFFFFFFFF);
      check("t2_time", pulse_t[0], tw[0] + PERIOD);
    end

    // 3: back-to-back words, then idle
    clear_log();
    for (int i = 0; i < 3; i++) begin
      send_word(words3[i]);
      tw[i] = t_last;
    end
    send_commas(2);
    check("t3_pulses", 32'(pulse_t.size()), 32'd3);
    if (pulse_t.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t3_data%0d", i), pulse_d[i], words3[i]);
        check($sformatf("t3_time%0d", i), pulse_t[i], tw[i] + PERIOD);
      end
      check("t3_spacing", pulse_t[2] - pulse_t[1], 32'd160);
    end
    check("t3_hold", data_out, 32'hCCCCCCCC);
    check("t3_valid_idle", {31'b0, valid_out}, 32'h0);
`ifdef PHY_RX_WORD_CNT_EN
    check("t3_word_count", {16'b0, word_count_out}, 32'd4);
`endif

    // 4: stream 3 bits off byte alignment
    do_reset();
    check("t4_rst_data", data_out, 32'h0);
    for (int i = 2; i >= 0; i--) send_bit(prefix[i], prefix[i]);
    send_commas(4);
    t4 = t_last;
    send_commas(1);
    check("t4_rise_time", t_rise, t4 + PERIOD);
    send_word(32'hBBBBBBBB);
    tw[0] = t_last;
    send_word(32'hAAAAAAAA);
    tw[1] = t_last;
    send_commas(1);
    check("t4_pulses", 32'(pulse_t.size()), 32'd2);
    if (pulse_t.size() == 2) begin
      check("t4_data0", pulse_d[0], 32'hBBBBBBBB);
      check("t4_data1", pulse_d[1], 32'hAAAAAAAA);
      check("t4_time1", pulse_t[1], tw[1] + PERIOD);
    end

    // 5: broken comma run falls back to SEARCH
    do_reset();
    send_commas(3);
    send_slot(8'h00, 8'h00);
    send_commas(1);
    check("t5_no_lock", {31'b0, active_out}, 32'h0);
    check("t5_no_rise", t_rise, 32'h0);
    send_commas(3);
    t4 = t_last;
    send_commas(1);
    check("t5_relock_time", t_rise, t4 + PERIOD);

    // 6: reset after slot A discards the partial word
    do_reset();
    send_commas(4);
    send_slot(8'h12, 8'h34);
    reset_L = 1'b0;
    @(posedge clk_32f);
    @(negedge clk_32f);
    reset_L = 1'b1;
    check("t6_rst_data", data_out, 32'h0);
    check("t6_rst_valid", {31'b0, valid_out}, 32'h0);
    check("t6_rst_active", {31'b0, active_out}, 32'h0);
    send_slot(8'h56, 8'h78);
    send_commas(1);
    check("t6_no_pulse", 32'(pulse_t.size()), 32'd0);
    check("t6_unlocked", {31'b0, active_out}, 32'h0);
    send_commas(3);
    send_commas(1);
    check("t6_relocked", {31'b0, active_out}, 32'h1);
    send_word(32'h12345678);
    send_commas(1);
    check("t6_pulses", 32'(pulse_t.size()), 32'd1);
    if (pulse_t.size() == 1) check("t6_data", pulse_d[0], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
